flux_decoder: RTL and testbench

FLUX_DECODER -- requirements
Module: flux_decoder

---
 rtl/flux_decoder.sv | 194 +++++++++++++++++++
 tb/tb_flux_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/flux_decoder.sv
// rtl/flux_decoder.sv - MFM flux-interval decoder with lock tracking
module flux_decoder #(
  parameter int clkspd  = 25000000,
  parameter int bitrate = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Data,
  output logic o_Bit,
  output logic o_Bit_DV,
  output logic o_Error,
  output logic o_Locked
);

  // One MFM cell in clocks; all window edges are half-cell multiples of it.
  localparam int CELL = clkspd / (2 * bitrate);

  // Interval window boundaries: below LIM_2 is too short, at or above LIM_MAX
  // is a timeout; in between, LIM_3 and LIM_4 split 2, 3 and 4 cell intervals.
  localparam logic [9:0] C_LIM_2   = 10'((3 * CELL) / 2);
  localparam logic [9:0] C_LIM_3   = 10'((5 * CELL) / 2);
  localparam logic [9:0] C_LIM_4   = 10'((7 * CELL) / 2);
  localparam logic [9:0] C_LIM_MAX = 10'((9 * CELL) / 2);

  localparam logic [9:0] C_CNT_SAT  = 10'd1023;
  localparam logic [4:0] C_GOOD_MAX = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_EMIT    = 2'd2
  } t_state;

  t_state     r_state;
  t_state     w_next_state;

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       w_edge;

  logic [9:0] r_count;
  logic [4:0] r_good;

  // Cells still to be shifted out after the one currently being presented.
  logic [1:0] r_remaining;
  logic [1:0] w_remaining;

  logic       r_bit;
  logic       r_bit_dv;
  logic       r_error;
  logic       w_bit;
  logic       w_bit_dv;
  logic       w_error;
  logic       w_good_inc;
  logic       w_good_clr;

  // Flux pulses are active-low, so the falling edge of the synchronized
  // input marks a flux transition.
  assign w_edge = r_prev & ~r_sync2;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_Data;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Interval counter: restarts at 1 on every edge and saturates when idle.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_count <= 10'd0;
    end else if (w_edge) begin
      r_count <= 10'd1;
    end else if (r_count != C_CNT_SAT) begin
      r_count <= r_count + 10'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: classify intervals in MEASURE, shift cells in EMIT.
  always_comb begin
    w_next_state = r_state;
    w_remaining  = r_remaining;
    w_bit        = 1'b0;
    w_bit_dv     = 1'b0;
    w_error      = 1'b0;
    w_good_inc   = 1'b0;
    w_good_clr   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // The first edge only becomes the timing reference.
        if (w_edge) begin
          w_next_state = S_MEASURE;
        end
      end

      S_MEASURE: begin
        // A timeout wins even if an edge lands on the same cycle.
        if (r_count >= C_LIM_MAX) begin
          w_error      = 1'b1;
          w_good_clr   = 1'b1;
          w_next_state = S_IDLE;
        end else if (w_edge) begin
          if (r_count < C_LIM_2) begin
            // Too short: report it and let this edge be the new reference.
            w_error    = 1'b1;
            w_good_clr = 1'b1;
          end else begin
            // First cell of a valid interval is always 0; the final 1 is
            // produced from EMIT once the remaining count reaches one.
            w_good_inc   = 1'b1;
            w_bit_dv     = 1'b1;
            w_bit        = 1'b0;
            w_next_state = S_EMIT;
            if (r_count < C_LIM_3) begin
              w_remaining = 2'd1;
            end else if (r_count < C_LIM_4) begin
              w_remaining = 2'd2;
            end else begin
              w_remaining = 2'd3;
            end
          end
        end
      end

      S_EMIT: begin
        if (r_remaining != 2'd0) begin
          w_bit_dv    = 1'b1;
          w_bit       = (r_remaining == 2'd1);
          w_remaining = r_remaining - 2'd1;
        end else begin
          w_next_state = S_MEASURE;
        end
        // Edges here are always too close; the scheduled cells still finish.
        if (w_edge) begin
          w_error    = 1'b1;
          w_good_clr = 1'b1;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Registered cell/error strobes and the cell shift counter.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_bit       <= 1'b0;
      r_bit_dv    <= 1'b0;
      r_error     <= 1'b0;
      r_remaining <= 2'd0;
    end else begin
      r_bit       <= w_bit;
      r_bit_dv    <= w_bit_dv;
      r_error     <= w_error;
      r_remaining <= w_remaining;
    end
  end

  // Good-interval counter: every error clears it, so lock drops with o_Error.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_good <= 5'd0;
    end else if (w_good_clr) begin
      r_good <= 5'd0;
    end else if (w_good_inc && (r_good != C_GOOD_MAX)) begin
      r_good <= r_good + 5'd1;
    end
  end

  assign o_Bit    = r_bit;
  assign o_Bit_DV = r_bit_dv;
  assign o_Error  = r_error;
  assign o_Locked = (r_good == C_GOOD_MAX);

endmodule

// File: tb/tb_flux_decoder.sv
// tb/tb_flux_decoder.sv - randomized edge-schedule bench for flux_decoder
module tb_flux_decoder;

  localparam int NCYC = 50000;

  logic i_Clk   = 1'b0;
  logic i_Reset = 1'b1;
  logic i_Data  = 1'b1;
  logic o_Bit;
  logic o_Bit_DV;
  logic o_Error;
  logic o_Locked;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Stimulus plan: edge drive cycles and reset windows [on, off).
  int edges[$];
  int rst_on[$];
  int rst_off[$];
  int t_plan;
  int t_end;
  int t_sat;

  bit drv_low[NCYC];
  bit rst_lvl[NCYC];
  bit exp_dv[NCYC];
  bit exp_bit[NCYC];
  bit exp_err[NCYC];
  bit exp_lock[NCYC];

  // Reference model state.
  bit m_act;
  int m_ref;
  int m_good;
  int lock_pos;
  bit cur_lock;

  flux_decoder #(
    .clkspd (25000000),
    .bitrate(250000)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Data  (i_Data),
    .o_Bit   (o_Bit),
    .o_Bit_DV(o_Bit_DV),
    .o_Error (o_Error),
    .o_Locked(o_Locked)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
  endtask

  task automatic next_edge(input int gap);
    t_plan += gap;
    edges.push_back(t_plan);
  endtask

  function automatic void set_lock(input int from, input bit v);
    for (int c = lock_pos; c < from && c < NCYC; c++) exp_lock[c] = cur_lock;
    if (from > lock_pos) lock_pos = from;
    cur_lock = v;
  endfunction

  // Timeout whose decision cycle (ref + 225) falls before cycle upto.
  function automatic void m_settle(input int upto);
    if (m_act && (m_ref + 225 < upto)) begin
      exp_err[m_ref + 226] = 1'b1;
      m_good = 0;
      set_lock(m_ref + 226, 1'b0);
      m_act = 1'b0;
    end
  endfunction

  function automatic void m_edge(input int e);
    int n;
    int k;
    m_settle(e);
    if (!m_act) begin
      m_act = 1'b1;
      m_ref = e;
    end else begin
      n = e - m_ref;
      if (n >= 225) begin
        exp_err[m_ref + 226] = 1'b1;
        m_good = 0;
        set_lock(m_ref + 226, 1'b0);
        m_act = 1'b0;
      end else if (n < 75) begin
        exp_err[e + 1] = 1'b1;
        m_good = 0;
        set_lock(e + 1, 1'b0);
        m_ref = e;
      end else begin
        k = (n < 125) ? 2 : (n < 175) ? 3 : 4;
        for (int j = 1; j <= k; j++) exp_dv[e + j] = 1'b1;
        exp_bit[e + k] = 1'b1;
        if (m_good < 16) m_good++;
        set_lock(e + 1, m_good == 16);
        m_ref = e;
      end
    end
  endfunction

  task automatic build_model();
    int ri = 0;
    m_act = 1'b0;
    m_ref = 0;
    m_good = 0;
    lock_pos = 0;
    cur_lock = 1'b0;
    foreach (edges[i]) begin
      // Edge detected two cycles after the drive cycle (2-flop synchronizer).
      int e = edges[i] + 2;
      while (ri < rst_on.size() && rst_on[ri] <= e) begin
        m_settle(rst_on[ri]);
        m_act = 1'b0;
        m_good = 0;
        set_lock(rst_on[ri], 1'b0);
        ri++;
      end
      m_edge(e);
    end
    m_settle(t_end);
    set_lock(t_end, 1'b0);
    foreach (rst_on[i]) begin
      for (int c = rst_on[i]; c <= rst_off[i]; c++) begin
        exp_dv[c] = 1'b0;
        exp_bit[c] = 1'b0;
        exp_err[c] = 1'b0;
        exp_lock[c] = 1'b0;
      end
    end
  endtask

  initial begin
    int r;
    rst_on.push_back(0);
    rst_off.push_back(5);
    t_plan = 20;
    edges.push_back(t_plan);
    // Steady 2-cell stream long enough to reach lock.
    repeat (20) next_edge(100);
    // Glitch while locked, then normal decoding resumes.
    next_edge(40);
    next_edge(100);
    next_edge(100);
    next_edge(150);
    next_edge(200);
    // Window boundaries; 225 times out and drops the edge.
    next_edge(74);
    next_edge(75);
    next_edge(124);
    next_edge(125);
    next_edge(224);
    next_edge(225);
    next_edge(100);
    next_edge(100);
    // Edge landing inside a 4-cell emission.
    next_edge(200);
    next_edge(3);
    next_edge(100);
    // Reset two cycles into a 4-cell emission.
    next_edge(200);
    rst_on.push_back(t_plan + 4);
    rst_off.push_back(t_plan + 10);
    next_edge(30);
    next_edge(100);
    // Random intervals: mostly in-window, some short, some timeouts.
    repeat (100) begin
      r = $urandom_range(0, 9);
      if (r < 7) next_edge($urandom_range(70, 230));
      else if (r < 9) next_edge($urandom_range(3, 74));
      else next_edge($urandom_range(226, 400));
    end
    // Long silence after one edge.
    next_edge(100);
    t_sat = t_plan + 2000;
    t_end = t_plan + 2100;

    foreach (edges[i]) begin
      drv_low[edges[i]] = 1'b1;
      drv_low[edges[i] + 1] = 1'b1;
    end
    foreach (rst_on[i]) begin
      for (int c = rst_on[i]; c < rst_off[i]; c++) rst_lvl[c] = 1'b1;
    end
    build_model();

    while (cyc < t_end) begin
      @(posedge i_Clk);
      #1;
      i_Reset = rst_lvl[cyc];
      i_Data = !drv_low[cyc];
      @(negedge i_Clk);
      check("bit_dv", int'(o_Bit_DV), int'(exp_dv[cyc]));
      check("error", int'(o_Error), int'(exp_err[cyc]));
      check("locked", int'(o_Locked), int'(exp_lock[cyc]));
      if (exp_dv[cyc]) check("bit", int'(o_Bit), int'(exp_bit[cyc]));
      if (cyc == t_sat) check("count_sat", int'(dut.r_count), 1023);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
